rx_packet_parser: RTL and testbench

// - Upstream stage of the Q-table update block: accepts received packets as a 16-bit word stream and extracts the header fields.
// - Buffers the knownCH list, filters the packet, then pulses en to the updater and holds the fields stable until the updater reports done.

---
 rtl/rx_packet_parser_pkg.sv | 36 +++
 rtl/rx_kch_buffer.sv | 27 ++
 rtl/rx_packet_parser.sv | 173 +++++++++++++++++
 tb/tb_rx_packet_parser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_packet_parser_pkg.sv
// Shared definitions for the Q-table receive path: packet type codes, header layout,
// word offsets inside a packet and the parser state encoding.
package rx_packet_parser_pkg;

   localparam int WORD_WIDTH = 16;
   typedef logic [WORD_WIDTH-1:0] word_t;

   typedef enum logic [2:0] {
      PKT_HELLO  = 3'd0,
      PKT_DATA   = 3'd1,
      PKT_ACK    = 3'd2,
      PKT_JOIN   = 3'd3,
      PKT_LEAVE  = 3'd4,
      PKT_CH_ADV = 3'd5,
      PKT_ROUTE  = 3'd6,
      PKT_RSVD   = 3'd7
   } pkt_type_e;

   // Word 0 layout: {type[2:0], rsvd[4:0], kch[7:0]}
   localparam int HDR_TYPE_MSB = 15;
   localparam int HDR_TYPE_LSB = 13;
   localparam int HDR_KCH_MSB  = 7;
   localparam int HDR_KCH_LSB  = 0;

   localparam word_t OFF_SRC     = 16'd1;
   localparam word_t OFF_HOPS    = 16'd2;
   localparam word_t OFF_CLUSTER = 16'd3;
   localparam word_t OFF_ENERGY  = 16'd4;
   localparam word_t OFF_QVALUE  = 16'd5;
   localparam word_t OFF_KCH     = 16'd6;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_FIELDS, S_KCH, S_CHECK, S_DISPATCH, S_WAIT, S_DROP
   } state_e;

endpackage

// File: rtl/rx_kch_buffer.sv
// knownCH register file: synchronous write, combinational read that returns zero
// for any index at or beyond the current entry count.
module rx_kch_buffer
   import rx_packet_parser_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  word_t         wr_data,
   input  word_t         rd_sel,
   input  word_t         count,
   output word_t         rd_data
);

   word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Count of a dropped oversize packet may exceed DEPTH, so bound by both.
   assign rd_data = (rd_sel < count && rd_sel < word_t'(DEPTH)) ? mem[rd_sel[AW-1:0]] : '0;

endmodule

// File: rtl/rx_packet_parser.sv
// Receive packet parser feeding the Q-table updater. Define RX_CHECKSUM_EN to expect
// a trailing XOR checksum word on every packet.
module rx_packet_parser
   import rx_packet_parser_pkg::*;
#(
   parameter int         MAX_KCH     = 8,
   parameter logic [7:0] ACCEPT_MASK = 8'hFF
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [15:0] own_id,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic        en,
   output logic [2:0]  fPacketType,
   output logic [15:0] fSourceID,
   output logic [15:0] fSourceHops,
   output logic [15:0] fClusterID,
   output logic [15:0] fEnergyLeft,
   output logic [15:0] fQValue,
   output logic [15:0] fKnownCHCount,
   input  logic [15:0] kch_sel,
   output logic [15:0] fKnownCH,
   input  logic        upd_done,
   output logic        busy,
   output logic [7:0]  pkt_cnt,
   output logic [7:0]  drop_cnt
);

   localparam int KAW = (MAX_KCH > 1) ? $clog2(MAX_KCH) : 1;

   state_e     state, state_nx;
   word_t      w_idx, kch_q, last_idx, hdr_kch;
   logic [2:0] type_q;
   logic       accept, is_final, kch_wr, csum_bad, drop_inc, pkt_inc;
   logic [KAW-1:0] kch_addr;

   assign accept  = in_valid & in_ready;
   assign hdr_kch = word_t'(in_data[HDR_KCH_MSB:HDR_KCH_LSB]);

`ifdef RX_CHECKSUM_EN
   localparam word_t CS_WORDS = 16'd1;
   word_t csum;
   // Accumulating the checksum word too leaves zero for an intact packet.
   always_ff @(posedge clk) begin
      if (!nrst)       csum <= '0;
      else if (accept) csum <= (state == S_IDLE) ? in_data : (csum ^ in_data);
   end
   assign csum_bad = (csum != '0);
`else
   localparam word_t CS_WORDS = 16'd0;
   assign csum_bad = 1'b0;
`endif

   assign last_idx = kch_q + OFF_QVALUE + CS_WORDS;
   assign is_final = (w_idx == last_idx);
   assign kch_wr   = accept && (state == S_KCH) && (w_idx < kch_q + OFF_KCH);
   assign kch_addr = KAW'(w_idx - OFF_KCH);

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      en       = 1'b0;
      drop_inc = 1'b0;
      pkt_inc  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (hdr_kch > word_t'(MAX_KCH)) begin
                  state_nx = in_last ? S_IDLE : S_DROP;
                  drop_inc = in_last;
               end else if (in_last) begin
                  drop_inc = 1'b1;
               end else begin
                  state_nx = S_FIELDS;
               end
            end
         end
         S_FIELDS, S_KCH: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_last) begin
                  state_nx = is_final ? S_CHECK : S_IDLE;
                  drop_inc = !is_final;
               end else if (is_final) begin
                  state_nx = S_DROP;
               end else if (w_idx == OFF_QVALUE) begin
                  state_nx = S_KCH;
               end
            end
         end
         S_CHECK: begin
            if (fSourceID == own_id || !ACCEPT_MASK[type_q] || csum_bad) begin
               state_nx = S_IDLE;
               drop_inc = 1'b1;
            end else begin
               state_nx = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            en       = 1'b1;
            pkt_inc  = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT:  if (upd_done) state_nx = S_IDLE;
         S_DROP: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_nx = S_IDLE;
               drop_inc = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state       <= S_IDLE;
         w_idx       <= '0;
         kch_q       <= '0;
         type_q      <= '0;
         fSourceID   <= '0;
         fSourceHops <= '0;
         fClusterID  <= '0;
         fEnergyLeft <= '0;
         fQValue     <= '0;
         pkt_cnt     <= '0;
         drop_cnt    <= '0;
      end else begin
         state <= state_nx;
         if (pkt_inc  && pkt_cnt  != 8'hFF) pkt_cnt  <= pkt_cnt + 8'd1;
         if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         if (accept) begin
            if (state == S_IDLE) begin
               type_q <= in_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
               kch_q  <= hdr_kch;
               w_idx  <= OFF_SRC;
            end else begin
               w_idx <= w_idx + 16'd1;
               if (state == S_FIELDS) begin
                  case (w_idx)
                     OFF_SRC:     fSourceID   <= in_data;
                     OFF_HOPS:    fSourceHops <= in_data;
                     OFF_CLUSTER: fClusterID  <= in_data;
                     OFF_ENERGY:  fEnergyLeft <= in_data;
                     OFF_QVALUE:  fQValue     <= in_data;
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   assign fPacketType   = type_q;
   assign fKnownCHCount = kch_q;
   assign busy          = (state != S_IDLE);

   rx_kch_buffer #(.DEPTH(MAX_KCH), .AW(KAW)) u_kch_buffer (
      .clk     (clk),
      .wr_en   (kch_wr),
      .wr_addr (kch_addr),
      .wr_data (in_data),
      .rd_sel  (kch_sel),
      .count   (kch_q),
      .rd_data (fKnownCH)
   );

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed bench for rx_packet_parser (MAX_KCH=8, type 7 masked off).
module tb_rx_packet_parser;

   logic        clk = 1'b0, nrst = 1'b0;
   logic [15:0] own_id = 16'h0001, in_data = '0, kch_sel = '0;
   logic        in_valid = 1'b0, in_last = 1'b0, upd_done = 1'b0;
   logic        in_ready, en, busy;
   logic [2:0]  fPacketType;
   logic [15:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCHCount, fKnownCH;
   logic [7:0]  pkt_cnt, drop_cnt;

   int vecs = 0, errs = 0, en_seen = 0, pkt_exp = 0, drop_exp = 0;
   logic [15:0] pkt [0:15];
   logic [15:0] cs_flip = '0;
`ifdef RX_CHECKSUM_EN
   localparam int CSW = 1;
`else
   localparam int CSW = 0;
`endif

   rx_packet_parser #(.MAX_KCH(8), .ACCEPT_MASK(8'h7F)) dut (
      .clk(clk), .nrst(nrst), .own_id(own_id), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .en(en), .fPacketType(fPacketType),
      .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fClusterID(fClusterID),
      .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .fKnownCHCount(fKnownCHCount),
      .kch_sel(kch_sel), .fKnownCH(fKnownCH), .upd_done(upd_done), .busy(busy),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (en === 1'b1) en_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_word(input logic [15:0] d, input logic l);
      in_valid = 1'b1; in_data = d; in_last = l;
      step();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic load(input logic [2:0] typ, input int kch, input logic [15:0] src);
      pkt[0] = {typ, 5'b0, 8'(kch)};
      pkt[1] = src;     pkt[2] = 16'h0003; pkt[3] = 16'h0007;
      pkt[4] = 16'h0064; pkt[5] = 16'h1234;
      for (int i = 0; i < kch; i++) pkt[6+i] = 16'h0009 + 16'(i);
   endtask

   task automatic send_pkt(input int len);
      logic [15:0] x;
      x = '0;
      for (int i = 0; i < len; i++) begin
         x ^= pkt[i];
         send_word(pkt[i], (CSW == 0) && (i == len - 1));
      end
      if (CSW != 0) send_word(x ^ cs_flip, 1'b1);
   endtask

   task automatic dispatch(input string tag);
      chk({tag, "_check_ready"}, in_ready, 1'b0);
      chk({tag, "_check_en"}, en, 1'b0);
      step();
      chk({tag, "_en_pulse"}, en, 1'b1);
      step();
      pkt_exp++;
      chk({tag, "_en_low"}, en, 1'b0);
      chk({tag, "_pkt_cnt"}, pkt_cnt, 8'(pkt_exp));
   endtask

   task automatic release_upd();
      upd_done = 1'b1; step(); upd_done = 1'b0;
      chk("release_busy", busy, 1'b0);
   endtask

   initial begin
      step(); step();
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_en", en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_type", fPacketType, 3'd0);
      chk("rst_src", fSourceID, 16'h0);
      chk("rst_count", fKnownCHCount, 16'h0);
      chk("rst_kch_rd", fKnownCH, 16'h0);
      chk("rst_cnts", {pkt_cnt, drop_cnt}, 16'h0);
      nrst = 1'b1; step();

      // valid packet, then hold the updater off for 20 cycles
      load(3'd1, 2, 16'h0005); send_pkt(8); dispatch("pkt1");
      chk("pkt1_type", fPacketType, 3'd1);
      chk("pkt1_src", fSourceID, 16'h0005);
      chk("pkt1_hops", fSourceHops, 16'h0003);
      chk("pkt1_cluster", fClusterID, 16'h0007);
      chk("pkt1_energy", fEnergyLeft, 16'h0064);
      chk("pkt1_qval", fQValue, 16'h1234);
      chk("pkt1_count", fKnownCHCount, 16'd2);
      kch_sel = 16'd1; #1 chk("pkt1_kch1", fKnownCH, 16'h000A);
      kch_sel = 16'd0; #1 chk("pkt1_kch0", fKnownCH, 16'h0009);
      kch_sel = 16'd2; #1 chk("pkt1_kch2_oob", fKnownCH, 16'h0000);
      in_valid = 1'b1; in_data = 16'hFFFF;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("wait_ready", in_ready, 1'b0);
         chk("wait_src", fSourceID, 16'h0005);
         chk("wait_qval", fQValue, 16'h1234);
      end
      in_valid = 1'b0;
      release_upd();
      chk("pkt1_ready_after", in_ready, 1'b1);
      chk("pkt1_en_count", en_seen, 1);

      // src == own_id
      load(3'd1, 2, 16'h0001); send_pkt(8);
      chk("own_busy_check", busy, 1'b1);
      step(); drop_exp++;
      chk("own_busy", busy, 1'b0);
      chk("own_ready", in_ready, 1'b1);
      chk("own_drop", drop_cnt, 8'(drop_exp));
      chk("own_no_en", en_seen, 1);

      // kch above MAX_KCH: consume until in_last
      send_word(16'h2009, 1'b0);
      chk("big_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) send_word(16'h1111, 1'b0);
      chk("big_busy_mid", busy, 1'b1);
      send_word(16'h2222, 1'b1); drop_exp++;
      chk("big_busy", busy, 1'b0);
      chk("big_drop", drop_cnt, 8'(drop_exp));
      chk("big_no_en", en_seen, 1);

      // in_last on w3
      load(3'd1, 2, 16'h0005);
      for (int i = 0; i < 3; i++) send_word(pkt[i], 1'b0);
      send_word(pkt[3], 1'b1); drop_exp++;
      chk("early_busy", busy, 1'b0);
      chk("early_drop", drop_cnt, 8'(drop_exp));

      // next valid packet after malformed one, no knownCH
      load(3'd2, 0, 16'h0042); send_pkt(6); dispatch("pkt0kch");
      chk("pkt0kch_src", fSourceID, 16'h0042);
      chk("pkt0kch_type", fPacketType, 3'd2);
      chk("pkt0kch_count", fKnownCHCount, 16'd0);
      kch_sel = 16'd0; #1 chk("pkt0kch_rd", fKnownCH, 16'h0000);
      release_upd();

      // type 7 rejected by mask
      load(3'd7, 1, 16'h0005); send_pkt(7); step(); drop_exp++;
      chk("mask_drop", drop_cnt, 8'(drop_exp));
      chk("mask_no_en", en_seen, 2);

      // expected final word without in_last
      load(3'd1, 1, 16'h0005);
      for (int i = 0; i < 7; i++) send_word(pkt[i], 1'b0);
      if (CSW != 0) send_word(16'h0000, 1'b0);
      chk("nolast_ready", in_ready, 1'b1);
      chk("nolast_busy", busy, 1'b1);
      send_word(16'hBEEF, 1'b1); drop_exp++;
      chk("nolast_idle", busy, 1'b0);
      chk("nolast_drop", drop_cnt, 8'(drop_exp));

      // kch == MAX_KCH boundary
      load(3'd3, 8, 16'h0005); send_pkt(14); dispatch("full");
      chk("full_count", fKnownCHCount, 16'd8);
      kch_sel = 16'd7; #1 chk("full_kch7", fKnownCH, 16'h0010);
      kch_sel = 16'd8; #1 chk("full_kch8_oob", fKnownCH, 16'h0000);
      release_upd();

`ifdef RX_CHECKSUM_EN
      cs_flip = 16'h0001;
      load(3'd1, 2, 16'h0005); send_pkt(8); step(); drop_exp++;
      cs_flip = '0;
      chk("cs_drop", drop_cnt, 8'(drop_exp));
      chk("cs_no_en", en_seen, 3);
`endif

      // reset mid-knownCH
      load(3'd1, 2, 16'h0005);
      for (int i = 0; i < 7; i++) send_word(pkt[i], 1'b0);
      chk("mid_busy", busy, 1'b1);
      nrst = 1'b0; step();
      chk("mid_rst_ready", in_ready, 1'b1);
      chk("mid_rst_en", en, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_src", fSourceID, 16'h0);
      chk("mid_rst_qval", fQValue, 16'h0);
      chk("mid_rst_type", fPacketType, 3'd0);
      chk("mid_rst_count", fKnownCHCount, 16'h0);
      chk("mid_rst_cnts", {pkt_cnt, drop_cnt}, 16'h0);
      nrst = 1'b1; step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
